// File: rtl/twelve_state_seq_checker_pkg.sv
// Shared definitions for the twelve-state counter and its checker.
// next_count is the single source of the legal successor rule.
package twelve_state_seq_checker_pkg;

  localparam int SEQ_MOD = 12;
  localparam int SEQ_CW = 4;
  localparam logic [SEQ_CW-1:0] SEQ_PRE_RUN = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED,
    ERR
  } state_t;

  typedef struct packed {
    logic              ok;
    logic [SEQ_CW-1:0] val;
  } nxt_t;

  // ok = 0 marks an out-of-range value that has no legal successor
  function automatic nxt_t next_count(
    input logic [SEQ_CW-1:0] prev,
    input logic              en,
    input int                mod = SEQ_MOD,
    input logic [SEQ_CW-1:0] pre = SEQ_PRE_RUN
  );
    nxt_t r;
    r.ok  = 1'b1;
    r.val = prev;
    if (!en)
      r.val = prev;
    else if (prev == pre || prev == SEQ_CW'(mod - 1))
      r.val = '0;
    else if (prev >= SEQ_CW'(mod))
      r.ok = 1'b0;
    else
      r.val = prev + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/twelve_state_seq_checker_sat_err_counter.sv
// Saturating up-counter with synchronous clear and increment.
// A clear coinciding with an increment yields a count of one.
module twelve_state_seq_checker_sat_err_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= {{(W-1){1'b0}}, i_inc};
    else if (i_inc && r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/twelve_state_seq_checker.sv
// Monitors the twelve-state counter: locks onto the sequence,
// then flags breaks, counts errors and reports wraps.
module twelve_state_seq_checker
  import twelve_state_seq_checker_pkg::*;
#(
  parameter int            MOD      = SEQ_MOD,
  parameter int            CW       = SEQ_CW,
  parameter logic [CW-1:0] PRE_RUN  = SEQ_PRE_RUN,
  parameter int            LOCK_CNT = 4,
  parameter int            ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en_in,
  input  logic [CW-1:0]    count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_flag,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [CW-1:0]    pos
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_prev_cnt;
  logic          r_prev_en;
  logic [3:0]    r_run;
  logic [3:0]    w_run_nxt;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_nxt;
  logic          r_err_pulse;
  logic          w_err_pulse;
  logic          r_wrap_pulse;
  logic          w_wrap_pulse;
  logic          w_inc;
  logic          w_legal;
  nxt_t          w_nxt;

  assign w_nxt   = next_count(r_prev_cnt, r_prev_en, MOD, PRE_RUN);
  assign w_legal = w_nxt.ok && (count_in == w_nxt.val);

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_pos_nxt    = r_pos;
    w_err_pulse  = 1'b0;
    w_wrap_pulse = 1'b0;
    w_inc        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = ACQ;
        w_run_nxt   = '0;
      end
      ACQ: begin
        if (!w_legal) begin
          w_run_nxt = '0;
        end else if (r_run == 4'(LOCK_CNT - 1)) begin
          w_state_nxt = LOCKED;
          w_run_nxt   = '0;
          w_pos_nxt   = count_in;
        end else begin
          w_run_nxt = r_run + 4'd1;
        end
      end
      LOCKED: begin
        if (w_legal) begin
          w_pos_nxt    = count_in;
          w_wrap_pulse = (r_prev_cnt == CW'(MOD - 1)) &&
                         (count_in == '0);
        end else begin
          w_err_pulse = 1'b1;
          w_inc       = 1'b1;
          w_state_nxt = ERR;
          w_pos_nxt   = PRE_RUN;
        end
      end
      ERR: begin
        if (clr_err) begin
          w_state_nxt = ACQ;
          w_run_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev_cnt   <= PRE_RUN;
      r_prev_en    <= 1'b0;
      r_run        <= '0;
      r_pos        <= PRE_RUN;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_cnt   <= count_in;
      r_prev_en    <= cnt_en_in;
      r_run        <= w_run_nxt;
      r_pos        <= w_pos_nxt;
      r_err_pulse  <= w_err_pulse;
      r_wrap_pulse <= w_wrap_pulse;
    end
  end

  twelve_state_seq_checker_sat_err_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(clr_err),
    .i_inc(w_inc),
    .o_cnt(err_cnt)
  );

  assign locked     = (r_state == LOCKED);
  assign err_flag   = (r_state == ERR);
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign pos        = r_pos;

endmodule

// File: tb/tb_twelve_state_seq_checker.sv
// Directed bench for the sequence checker and its error counter.
module tb_twelve_state_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cnt = 4'hF;

  logic       lk, ef, ep, wp;
  logic [7:0] ec;
  logic [3:0] ps;
  logic       lk2, ef2, ep2, wp2;
  logic [1:0] ec2;
  logic [3:0] ps2;

  logic       s_clr = 1'b0;
  logic       s_inc = 1'b0;
  logic [1:0] s_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  twelve_state_seq_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_en_in (en),
    .count_in  (cnt),
    .clr_err   (clr),
    .locked    (lk),
    .err_flag  (ef),
    .err_pulse (ep),
    .err_cnt   (ec),
    .wrap_pulse(wp),
    .pos       (ps)
  );

  twelve_state_seq_checker #(
    .ERR_W(2)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .cnt_en_in (en),
    .count_in  (cnt),
    .clr_err   (clr),
    .locked    (lk2),
    .err_flag  (ef2),
    .err_pulse (ep2),
    .err_cnt   (ec2),
    .wrap_pulse(wp2),
    .pos       (ps2)
  );

  twelve_state_seq_checker_sat_err_counter #(
    .W(2)
  ) u_sat (
    .clk  (clk),
    .rst  (rst),
    .i_clr(s_clr),
    .i_inc(s_inc),
    .o_cnt(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e,
                      input logic [3:0] c,
                      input logic cl = 1'b0);
    en  = e;
    cnt = c;
    clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lk", 32'(lk), 0);
    chk("rst_ef", 32'(ef), 0);
    chk("rst_ep", 32'(ep), 0);
    chk("rst_wp", 32'(wp), 0);
    chk("rst_ec", 32'(ec), 0);
    chk("rst_pos", 32'(ps), 32'hF);
    rst = 1'b0;

    step(1, 4'hF);
    chk("idle_lk", 32'(lk), 0);
    step(1, 0);
    step(1, 1);
    step(1, 2);
    chk("acq_lk", 32'(lk), 0);
    step(1, 3);
    chk("lock_lk", 32'(lk), 1);
    chk("lock_pos3", 32'(ps), 3);
    step(1, 4);
    chk("lock_pos4", 32'(ps), 4);
    chk("lock_ec", 32'(ec), 0);

    for (int v = 5; v <= 11; v++) step(1, 4'(v));
    chk("pre_wrap", 32'(wp), 0);
    step(1, 0);
    chk("wrap_hi", 32'(wp), 1);
    chk("wrap_pos", 32'(ps), 0);
    chk("wrap_ep", 32'(ep), 0);
    step(1, 1);
    chk("wrap_lo", 32'(wp), 0);
    chk("wrap_ep2", 32'(ep), 0);

    step(1, 2);
    step(1, 3);
    step(1, 4);
    step(0, 5);
    step(0, 5);
    step(0, 5);
    step(0, 5);
    chk("hold_lk", 32'(lk), 1);
    chk("hold_ef", 32'(ef), 0);
    chk("hold_ep", 32'(ep), 0);
    chk("hold_pos", 32'(ps), 5);

    step(0, 6);
    chk("brk_ep", 32'(ep), 1);
    chk("brk_ec", 32'(ec), 1);
    chk("brk_ef", 32'(ef), 1);
    chk("brk_lk", 32'(lk), 0);
    chk("brk_pos", 32'(ps), 32'hF);
    chk("brk_ec2", 32'(ec2), 1);

    step(0, 7);
    chk("err_ep", 32'(ep), 0);
    step(1, 13);
    step(1, 2);
    chk("err_ec", 32'(ec), 1);
    chk("err_ef", 32'(ef), 1);

    step(1, 2, 1);
    chk("clr_ec", 32'(ec), 0);
    chk("clr_ef", 32'(ef), 0);
    chk("clr_ec2", 32'(ec2), 0);
    step(1, 3);
    step(1, 4);
    step(1, 5);
    chk("relk_pre", 32'(lk), 0);
    step(1, 6);
    chk("relk", 32'(lk), 1);

    step(1, 9, 1);
    chk("coin_ep", 32'(ep), 1);
    chk("coin_ec", 32'(ec), 1);
    chk("coin_ec2", 32'(ec2), 1);
    chk("coin_ef", 32'(ef2), 1);

    step(1, 0, 1);
    chk("clr2_ec2", 32'(ec2), 0);
    for (int v = 1; v <= 4; v++) step(1, 4'(v));
    chk("relk2", 32'(lk2), 1);
    step(1, 7);
    chk("brk2_ec2", 32'(ec2), 1);
    chk("brk2_ep2", 32'(ep2), 1);

    step(1, 0, 1);
    for (int v = 1; v <= 8; v++) step(1, 4'(v));
    chk("pre_rst_lk", 32'(lk), 1);
    chk("pre_rst_pos", 32'(ps), 8);

    #2 rst = 1'b1;
    #1;
    chk("arst_lk", 32'(lk), 0);
    chk("arst_pos", 32'(ps), 32'hF);
    chk("arst_ef", 32'(ef), 0);
    chk("arst_wp", 32'(wp), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 9);
    step(1, 10);
    step(1, 11);
    step(1, 0);
    chk("rl_pre", 32'(lk), 0);
    step(1, 1);
    chk("rl_lk", 32'(lk), 1);
    chk("rl_pos", 32'(ps), 1);

    s_inc = 1'b1;
    @(posedge clk);
    #1 chk("sat1", 32'(s_cnt), 1);
    @(posedge clk);
    #1 chk("sat2", 32'(s_cnt), 2);
    @(posedge clk);
    #1 chk("sat3", 32'(s_cnt), 3);
    @(posedge clk);
    #1 chk("sat4", 32'(s_cnt), 3);
    @(posedge clk);
    #1 chk("sat5", 32'(s_cnt), 3);
    s_clr = 1'b1;
    @(posedge clk);
    #1 chk("sat_ci", 32'(s_cnt), 1);
    s_inc = 1'b0;
    @(posedge clk);
    #1 chk("sat_clr", 32'(s_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/twelve_state_seq_checker.md
Name: twelve_state_seq_checker

Overview:
- Receiving-end monitor for the twelve-state counter. Watches the counter's count bus and the enable that drives it, and confirms the counter follows the legal sequence.
- Acquires lock on the sequence, then reports sequence breaks, error totals and wrap events.
- Sits beside the counter in the integration top. Shares its clock domain and reset tree.

Parameters:
- MOD, 12, number of states in the legal sequence (values 0..MOD-1).
- CW, 4, count bus width.
- PRE_RUN, 4'hF, counter reset/pre-run value.
- LOCK_CNT, 4, consecutive legal transitions required to lock (range 1..15).
- ERR_W, 8, error counter width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cnt_en_in  input  1  the enable seen by the counter in this cycle
- count_in  input  CW  counter output, sampled every cycle
- clr_err  input  1  synchronous clear of the error state and err_cnt
- locked  output  1  high while the state machine is in LOCKED
- err_flag  output  1  sticky, high while in ERR
- err_pulse  output  1  one-cycle pulse per detected break while LOCKED
- err_cnt  output  ERR_W  saturating count of breaks
- wrap_pulse  output  1  one-cycle pulse on a legal MOD-1 -> 0 step while LOCKED
- pos  output  CW  last legal count while LOCKED, else PRE_RUN

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-operation):
  - state = IDLE; prev_cnt = PRE_RUN; prev_en = 0; run = 0.
  - All flags = 0; err_cnt = 0; pos = PRE_RUN.
- Sampling: each cycle, prev_cnt <= count_in and prev_en <= cnt_en_in.
- Expected value for the current count_in:
  - If prev_en = 0: expected = prev_cnt (hold).
  - If prev_en = 1 and prev_cnt = PRE_RUN: expected = 0.
  - If prev_en = 1 and prev_cnt = MOD-1: expected = 0.
  - Otherwise if prev_en = 1: expected = prev_cnt + 1.
  - Any prev_cnt in MOD..2^CW-1 other than PRE_RUN has no legal successor.
- legal = (count_in == expected), evaluated combinationally. All outputs are registered, so the response appears on the cycle after the offending sample.
- State machine:
  - IDLE: first cycle after reset deasserts. Captures the sample only, then goes to ACQ with run = 0.
  - ACQ:
    - legal: run++. If run == LOCK_CNT-1, go to LOCKED and clear run.
    - illegal: run = 0, stay in ACQ. No err_pulse, no err_cnt change.
  - LOCKED:
    - legal: pos <= count_in. wrap_pulse when prev_cnt = MOD-1 and count_in = 0.
    - illegal: err_pulse = 1, err_cnt saturating +1, go to ERR; pos <= PRE_RUN.
  - ERR: stays here regardless of input until clr_err, then goes to ACQ with run = 0.
- clr_err:
  - Sets err_cnt to 0 in any state.
  - In ERR, clears err_flag and moves to ACQ.
  - If clr_err and an illegal sample coincide in LOCKED, the clear happens first: err_cnt = 1, err_pulse = 1, next state ERR.
- err_cnt saturates at 2^ERR_W-1 and never wraps.
- A PRE_RUN sample seen in LOCKED is a break unless legal (only legal as a hold after PRE_RUN, which cannot occur once locked).
- locked = (state == LOCKED); err_flag = (state == ERR). Both are registered state decodes.

Decomposition:
- Shared package holds:
  - the state typedef (IDLE, ACQ, LOCKED, ERR);
  - the MOD and PRE_RUN constants, shared with the counter;
  - a next_count(prev, en) function, so the counter model and the checker use one definition.
- One natural sub-module: sat_err_counter. It is a parameterised ERR_W saturating up-counter with synchronous clear and increment inputs, reusable elsewhere.

Test Plan:
- Reset 0.
  - Stimulus: count_in = F, en = 1 for one cycle, then a clean count 0,1,2,3,4.
  - Required: locked rises one cycle after the sample "3" (4th legal step); err_cnt = 0; pos follows 3,4.
- Locked, enabled run 9,10,11,0,1.
  - Required: wrap_pulse exactly one cycle, the cycle after the 0 sample; no err_pulse.
- Locked at 5, en = 0 for 3 cycles with count_in = 5.
  - Required: stays locked, no error.
  - Then with en still 0, count_in = 6: err_pulse one cycle, err_cnt = 1, err_flag = 1, locked = 0, pos = F.
- In ERR, apply illegal samples 7,13,2.
  - Required: err_cnt stays 1.
  - Then clr_err: err_cnt = 0, err_flag = 0; relock after 4 further legal steps.
- ERR_W = 2, repeat lock/break/clr_err (err_cnt cleared) cycles.
  - Required: err_cnt climbs 1 after each break; separately forcing more than 3 breaks without clear saturates at 3.
  - Also: clr_err coincident with a break yields err_cnt = 1.
- Assert rst mid-run while locked at count 8.
  - Required: outputs go to reset values immediately, asynchronously; after release, lock is re-acquired only after IDLE + 4 legal steps.
